rs_param: RTL
=============

RS_PARAM -- requirements
Module: rs_param

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 16: number of entries, power of two, 2..64.
REQ-002 SHALL have parameter ROB_IDX_W, default 4: tag width; tag 0 means "operand ready".
REQ-003 SHALL have parameter CDB_N, default 2: number of result broadcast channels.
REQ-004 SHALL have parameters WORD_W 32, IMM_W 32, ADDR_W 32 and INSTR_ID_W 6: datapath, immediate, PC and opcode-id widths.
REQ-005 SHALL have these ports: clk_in  in  1  single clock, rising edge.
REQ-006 SHALL have port rst_n_in  in  1: asynchronous, active-low reset.
REQ-007 SHALL have port rdy_in  in  1: global enable; when low, no state changes.
REQ-008 SHALL have ports issue_valid_in in 1 and issue_ready_out out 1: allocate-request handshake.
REQ-009 SHALL have issue payload inputs instr_id_in INSTR_ID_W, imm_in IMM_W, pc_in ADDR_W and rob_pos_in ROB_IDX_W.
REQ-010 SHALL have, for each k in {1,2}, operand inputs rsk_tag_in ROB_IDX_W, rsk_reg_in WORD_W, rsk_rob_rdy_in 1 and rsk_rob_res_in WORD_W.
REQ-011 SHALL have CDB inputs cdb_en_in CDB_N, cdb_tag_in CDB_N*ROB_IDX_W and cdb_res_in CDB_N*WORD_W, flattened with channel 0 at the LSBs.
REQ-012 SHALL have input rob_head_in ROB_IDX_W: current ROB head, used for age ordering.
REQ-013 SHALL have input flush_in 1: mispredict clear.
REQ-014 SHALL have dispatch ports ex_valid_out out 1 and ex_ready_in in 1.
REQ-015 SHALL have dispatch payload outputs ex_instr_id_out, ex_imm_out, ex_rs1_out, ex_rs2_out, ex_pc_out and ex_rob_pos_out, all registered.
REQ-016 SHALL have free_cnt_out out clog2(RS_DEPTH)+1: count of free entries, registered.

Function
REQ-017 SHALL set issue_ready_out = (free_cnt_out != 0) && !flush_in.
REQ-018 SHALL accept an issue only when issue_valid_in && issue_ready_out && rdy_in, and write it into the lowest-index entry free per the registered busy vector; a slot freed in the same cycle SHALL NOT be reused that cycle.
REQ-019 SHALL capture each operand at issue, first match wins: tag==0 takes rsk_reg_in; then the lowest-index CDB channel with en && tag match; then rsk_rob_rdy_in takes rsk_rob_res_in; otherwise it stores the tag and waits.
REQ-020 SHALL, every enabled cycle, wake each busy waiting operand whose tag matches an enabled CDB channel (lowest channel wins); the value is stored and the tag cleared at the edge.
REQ-021 SHALL treat an entry as ready when it is busy and both stored tags are 0, judged on registered state only, so a same-cycle wakeup cannot dispatch that cycle.
REQ-022 SHALL select, among ready entries, the one with minimum age = (rob_id - rob_head_in) mod 2^ROB_IDX_W; on equal age the lower index wins.
REQ-023 SHALL treat the output register as loadable when !ex_valid_out || ex_ready_in; when it is loadable and a ready entry exists, SHALL load the payload, set ex_valid_out and clear that entry's busy bit at the same edge.
REQ-024 SHALL clear ex_valid_out when the output register is loadable and no entry is ready.
REQ-025 SHALL hold ex_valid_out and all ex_* outputs stable while ex_valid_out && !ex_ready_in.
REQ-026 SHALL give a minimum latency of 1 edge from an issue with ready operands to ex_valid_out: issue at edge t, entry ready during cycle t+1, ex_valid_out high after edge t+1.
REQ-027 SHALL update free_cnt_out at each edge as: previous count - issue accepted + entry dispatched; it never underflows or overflows.
REQ-028 SHALL, on flush_in (with rdy_in high), at the next edge clear all busy bits, set ex_valid_out=0 and set free_cnt_out=RS_DEPTH; flush SHALL override issue, wakeup and dispatch in that cycle.
REQ-029 SHALL, when rdy_in is low, hold all state and outputs; issue_ready_out still follows REQ-017.

Reset
REQ-030 SHALL, while rst_n_in is low, immediately and asynchronously force busy=0, ex_valid_out=0 and free_cnt_out=RS_DEPTH; ex_* payload outputs and entry contents are don't-care.
REQ-031 SHALL, on reset assertion mid-operation, lose all in-flight entries and the pending dispatch; reset deasserts synchronously to clk_in.

Verification
REQ-032 Reset then single issue, tags 0, rs1_reg=5, rs2_reg=7, rob_pos=3 -> ex_valid_out one edge after issue with rs1=5, rs2=7, rob_pos=3; free_cnt returns to 16.
REQ-033 Issue RS_DEPTH entries all waiting on tag 9 -> issue_ready_out=0 and free_cnt=0; cdb_en[1]=1, tag 9, res 0x55 -> all 16 wake, and dispatch follows in oldest-first order relative to rob_head.
REQ-034 rob_head=14, ready entries with rob_id 15, 1 and 14 -> dispatch order 14, 15, 1 (wrap-around age).
REQ-035 ex_ready_in=0 for 3 cycles with ex_valid_out=1 -> payload unchanged; entry count is not decremented again; release -> next entry follows on the next edge.
REQ-036 Same-cycle issue with rs1_tag=4, cdb0 tag 4 res 0xA, and rs1_rob_rdy=1 res 0xB -> stored v1=0xA.
REQ-037 flush_in concurrent with an issue and a pending stalled dispatch -> next edge ex_valid_out=0, free_cnt=16, and the issued entry is not stored.

Source files
------------

// File: rtl/rs_param.sv
// rs_param: reservation station with CDB wakeup, oldest-first dispatch and a registered dispatch slot.
module rs_param #(
  parameter int RS_DEPTH   = 16,
  parameter int ROB_IDX_W  = 4,
  parameter int CDB_N      = 2,
  parameter int WORD_W     = 32,
  parameter int IMM_W      = 32,
  parameter int ADDR_W     = 32,
  parameter int INSTR_ID_W = 6
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          rdy_in,
  input  logic                          issue_valid_in,
  output logic                          issue_ready_out,
  input  logic [INSTR_ID_W-1:0]         instr_id_in,
  input  logic [IMM_W-1:0]              imm_in,
  input  logic [ADDR_W-1:0]             pc_in,
  input  logic [ROB_IDX_W-1:0]          rob_pos_in,
  input  logic [ROB_IDX_W-1:0]          rs1_tag_in,
  input  logic [WORD_W-1:0]             rs1_reg_in,
  input  logic                          rs1_rob_rdy_in,
  input  logic [WORD_W-1:0]             rs1_rob_res_in,
  input  logic [ROB_IDX_W-1:0]          rs2_tag_in,
  input  logic [WORD_W-1:0]             rs2_reg_in,
  input  logic                          rs2_rob_rdy_in,
  input  logic [WORD_W-1:0]             rs2_rob_res_in,
  input  logic [CDB_N-1:0]              cdb_en_in,
  input  logic [CDB_N*ROB_IDX_W-1:0]    cdb_tag_in,
  input  logic [CDB_N*WORD_W-1:0]       cdb_res_in,
  input  logic [ROB_IDX_W-1:0]          rob_head_in,
  input  logic                          flush_in,
  output logic                          ex_valid_out,
  input  logic                          ex_ready_in,
  output logic [INSTR_ID_W-1:0]         ex_instr_id_out,
  output logic [IMM_W-1:0]              ex_imm_out,
  output logic [WORD_W-1:0]             ex_rs1_out,
  output logic [WORD_W-1:0]             ex_rs2_out,
  output logic [ADDR_W-1:0]             ex_pc_out,
  output logic [ROB_IDX_W-1:0]          ex_rob_pos_out,
  output logic [$clog2(RS_DEPTH):0]     free_cnt_out
);
  localparam int IW = $clog2(RS_DEPTH);
  localparam int CW = IW + 1;
  logic [RS_DEPTH-1:0]   busy, rdy_v, set, clr;
  logic [ROB_IDX_W-1:0]  t1 [RS_DEPTH];
  logic [ROB_IDX_W-1:0]  t2 [RS_DEPTH];
  logic [WORD_W-1:0]     v1 [RS_DEPTH];
  logic [WORD_W-1:0]     v2 [RS_DEPTH];
  logic [INSTR_ID_W-1:0] id [RS_DEPTH];
  logic [IMM_W-1:0]      imm [RS_DEPTH];
  logic [ADDR_W-1:0]     pc [RS_DEPTH];
  logic [ROB_IDX_W-1:0]  rob [RS_DEPTH];
  logic [ROB_IDX_W-1:0]  age [RS_DEPTH];
  logic [WORD_W:0]       w1 [RS_DEPTH];
  logic [WORD_W:0]       w2 [RS_DEPTH];
  logic [WORD_W:0]       s1, s2;
  logic [ROB_IDX_W-1:0]  c1_t, c2_t, best;
  logic [WORD_W-1:0]     c1_v, c2_v;
  logic [IW-1:0]         fidx, sidx;
  logic                  acc, any, load, disp;

  // Lowest-index CDB channel with a tag match wins; MSB of the result is the hit flag.
  function automatic logic [WORD_W:0] snoop(input logic [ROB_IDX_W-1:0] t,
                                            input logic [CDB_N-1:0] en,
                                            input logic [CDB_N*ROB_IDX_W-1:0] tg,
                                            input logic [CDB_N*WORD_W-1:0] rs);
    logic [WORD_W:0] r;
    r = '0;
    for (int c = CDB_N-1; c >= 0; c--)
      if (en[c] && tg[c*ROB_IDX_W +: ROB_IDX_W] == t) r = {1'b1, rs[c*WORD_W +: WORD_W]};
    return r;
  endfunction

  for (genvar i = 0; i < RS_DEPTH; i++) begin : g_e
    assign rdy_v[i] = busy[i] && t1[i] == '0 && t2[i] == '0;
    assign age[i]   = rob[i] - rob_head_in;
    assign w1[i]    = snoop(t1[i], cdb_en_in, cdb_tag_in, cdb_res_in);
    assign w2[i]    = snoop(t2[i], cdb_en_in, cdb_tag_in, cdb_res_in);
  end

  assign issue_ready_out = free_cnt_out != '0 && !flush_in;
  assign acc  = issue_valid_in && issue_ready_out && rdy_in;
  assign load = !ex_valid_out || ex_ready_in;
  assign disp = load && any;
  assign s1   = snoop(rs1_tag_in, cdb_en_in, cdb_tag_in, cdb_res_in);
  assign s2   = snoop(rs2_tag_in, cdb_en_in, cdb_tag_in, cdb_res_in);
  assign c1_t = (rs1_tag_in == '0 || s1[WORD_W] || rs1_rob_rdy_in) ? '0 : rs1_tag_in;
  assign c2_t = (rs2_tag_in == '0 || s2[WORD_W] || rs2_rob_rdy_in) ? '0 : rs2_tag_in;
  assign c1_v = rs1_tag_in == '0 ? rs1_reg_in : s1[WORD_W] ? s1[WORD_W-1:0] : rs1_rob_res_in;
  assign c2_v = rs2_tag_in == '0 ? rs2_reg_in : s2[WORD_W] ? s2[WORD_W-1:0] : rs2_rob_res_in;
  assign set  = acc ? (RS_DEPTH'(1) << fidx) : '0;
  assign clr  = disp ? (RS_DEPTH'(1) << sidx) : '0;

  always_comb begin
    fidx = '0;
    for (int i = RS_DEPTH-1; i >= 0; i--)
      if (!busy[i]) fidx = IW'(i);
  end

  // Strict less-than keeps the lower index on equal age.
  always_comb begin
    any  = 1'b0;
    sidx = '0;
    best = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      if (rdy_v[i] && (!any || age[i] < best)) begin
        any  = 1'b1;
        sidx = IW'(i);
        best = age[i];
      end
  end

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      busy         <= '0;
      ex_valid_out <= 1'b0;
      free_cnt_out <= CW'(RS_DEPTH);
    end else if (rdy_in) begin
      if (flush_in) begin
        busy         <= '0;
        ex_valid_out <= 1'b0;
        free_cnt_out <= CW'(RS_DEPTH);
      end else begin
        busy         <= (busy | set) & ~clr;
        free_cnt_out <= free_cnt_out - CW'(acc) + CW'(disp);
        if (load) ex_valid_out <= any;
      end
    end

  always_ff @(posedge clk_in)
    if (rdy_in && !flush_in) begin
      for (int i = 0; i < RS_DEPTH; i++)
        if (set[i]) begin
          t1[i]  <= c1_t;
          t2[i]  <= c2_t;
          v1[i]  <= c1_v;
          v2[i]  <= c2_v;
          id[i]  <= instr_id_in;
          imm[i] <= imm_in;
          pc[i]  <= pc_in;
          rob[i] <= rob_pos_in;
        end else begin
          if (busy[i] && t1[i] != '0 && w1[i][WORD_W]) begin
            v1[i] <= w1[i][WORD_W-1:0];
            t1[i] <= '0;
          end
          if (busy[i] && t2[i] != '0 && w2[i][WORD_W]) begin
            v2[i] <= w2[i][WORD_W-1:0];
            t2[i] <= '0;
          end
        end
      if (disp) begin
        ex_instr_id_out <= id[sidx];
        ex_imm_out      <= imm[sidx];
        ex_rs1_out      <= v1[sidx];
        ex_rs2_out      <= v2[sidx];
        ex_pc_out       <= pc[sidx];
        ex_rob_pos_out  <= rob[sidx];
      end
    end
endmodule
